// File: rtl/nco_pkg.sv
// nco_pkg: shared types, constants and the quarter-wave table generator for nco_iq.
package nco_pkg;

    // Which quarter of the full cycle a phase falls into.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // Cycles from a step_in strobe to the matching valid_out.
    localparam int NCO_LATENCY = 4;

    // Quarter-wave entry k, sampled half an LSB into each bin so the table is
    // mirror-symmetric and negating any entry stays inside the signed range.
    function automatic int tbl_value(input int k, input int lut_aw, input int amp_w);
        real amp;
        real ang;
        amp = real'((2 ** (amp_w - 1)) - 1);
        ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(2 ** lut_aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: quarter-wave sine ROM with two independent registered read ports,
// one for the cosine path and one for the sine path.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int AMP_W  = 16
) (
    input  logic              clk_in,
    input  logic [LUT_AW-1:0] addr_a,
    input  logic [LUT_AW-1:0] addr_b,
    output logic [AMP_W-2:0]  data_a,
    output logic [AMP_W-2:0]  data_b
);
    localparam int DEPTH = 2 ** LUT_AW;
    localparam int DW    = AMP_W - 1;

    logic [DW-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = DW'(tbl_value(k, LUT_AW, AMP_W));
    end

    // Registered read of both ports.
    // NOTE: ROM read registers get no reset; their contents are meaningless until a
    // valid sample flows through, and the stage-valid bits in the top gate them.
    always_ff @(posedge clk_in) begin
        data_a <= rom[addr_a];
        data_b <= rom[addr_b];
    end

endmodule

// File: rtl/nco_iq.sv
// nco_iq: runtime-tunable quadrature NCO. A shared phase accumulator feeds a
// 4-stage pipeline (accumulate, quadrant split, LUT read, negate) producing
// cosine on i_out and sine on q_out from one quarter-wave table.
module nco_iq
    import nco_pkg::*;
#(
    parameter int                 PHASE_W   = 32,
    parameter int                 LUT_AW    = 8,
    parameter int                 AMP_W     = 16,
    parameter logic [PHASE_W-1:0] FCW_RESET = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    step_in,
    input  logic                    sync_in,
    input  logic                    cfg_valid_in,
    output logic                    cfg_ready_out,
    input  logic [PHASE_W-1:0]      fcw_in,
    input  logic [PHASE_W-1:0]      poff_in,
    output logic signed [AMP_W-1:0] i_out,
    output logic signed [AMP_W-1:0] q_out,
    output logic                    valid_out,
    output logic                    wrap_out
);
    // Only the quadrant and table-index bits of the phase travel down the pipe.
    localparam int TH_W = LUT_AW + 2;

    logic [PHASE_W-1:0] acc, fcw, poff, fcw_sh, poff_sh;
    logic               pending;
    logic               cfg_accept;

    logic [PHASE_W-1:0] fcw_eff, poff_eff, acc_base;
    logic [PHASE_W:0]   acc_sum;
    logic [TH_W-1:0]    theta_top;

    logic               v_s1, wrap_s1;
    logic [TH_W-1:0]    theta_s1;

    logic [1:0]         quad_raw, quad_i_raw;
    quadrant_t          quad_q, quad_i;
    logic [LUT_AW-1:0]  idx, addr_q_nxt, addr_i_nxt;
    logic               neg_q_nxt, neg_i_nxt;

    logic               v_s2, wrap_s2, neg_q_s2, neg_i_s2;
    logic [LUT_AW-1:0]  addr_q_s2, addr_i_s2;

    logic               v_s3, wrap_s3, neg_q_s3, neg_i_s3;
    logic [AMP_W-2:0]   mag_i_s3, mag_q_s3;
    logic [AMP_W-1:0]   ext_i, ext_q;

    assign cfg_ready_out = !pending;
    assign cfg_accept    = cfg_valid_in && cfg_ready_out;

    // Effective increment/offset for this step (a pending config wins) and the
    // sync-aware accumulator base with its carry-out.
    // NOTE: every always_comb output gets a value on every path, so no latches form.
    always_comb begin
        fcw_eff   = pending ? fcw_sh  : fcw;
        poff_eff  = pending ? poff_sh : poff;
        acc_base  = sync_in ? '0 : acc;
        acc_sum   = {1'b0, acc_base} + {1'b0, fcw_eff};
        theta_top = TH_W'((acc_base + poff_eff) >> (PHASE_W - TH_W));
    end

    // Accumulator, live tuning registers and the config shadow.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc     <= '0;
            fcw     <= FCW_RESET;
            poff    <= '0;
            fcw_sh  <= '0;
            poff_sh <= '0;
            pending <= 1'b0;
        end else begin
            if (step_in) begin
                acc <= acc_sum[PHASE_W-1:0];
                if (pending) begin
                    fcw     <= fcw_sh;
                    poff    <= poff_sh;
                    pending <= 1'b0;
                end
            end else if (sync_in) begin
                acc <= '0;
            end
            if (cfg_accept) begin
                fcw_sh  <= fcw_in;
                poff_sh <= poff_in;
                pending <= 1'b1;
            end
        end
    end

    // S1: latch the sample phase and the carry of this step.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v_s1     <= 1'b0;
            wrap_s1  <= 1'b0;
            theta_s1 <= '0;
        end else begin
            v_s1 <= step_in;
            if (step_in) begin
                wrap_s1  <= acc_sum[PHASE_W];
                theta_s1 <= theta_top;
            end
        end
    end

    // Quadrant decode: cosine is sine one quadrant ahead; odd quadrants read the
    // table mirrored, the upper half-cycle is negated.
    always_comb begin
        quad_raw   = theta_s1[TH_W-1 -: 2];
        quad_i_raw = quad_raw + 2'd1;
        quad_q     = quadrant_t'(quad_raw);
        quad_i     = quadrant_t'(quad_i_raw);
        idx        = theta_s1[LUT_AW-1:0];
        addr_q_nxt = (quad_q inside {QUAD_1, QUAD_3}) ? ~idx : idx;
        addr_i_nxt = (quad_i inside {QUAD_1, QUAD_3}) ? ~idx : idx;
        neg_q_nxt  = quad_q inside {QUAD_2, QUAD_3};
        neg_i_nxt  = quad_i inside {QUAD_2, QUAD_3};
    end

    // S2: register table addresses and sign flags for both outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v_s2      <= 1'b0;
            wrap_s2   <= 1'b0;
            neg_q_s2  <= 1'b0;
            neg_i_s2  <= 1'b0;
            addr_q_s2 <= '0;
            addr_i_s2 <= '0;
        end else begin
            v_s2      <= v_s1;
            wrap_s2   <= wrap_s1;
            neg_q_s2  <= neg_q_nxt;
            neg_i_s2  <= neg_i_nxt;
            addr_q_s2 <= addr_q_nxt;
            addr_i_s2 <= addr_i_nxt;
        end
    end

    // S3: table read for I (port a) and Q (port b).
    nco_quarter_lut #(
        .LUT_AW (LUT_AW),
        .AMP_W  (AMP_W)
    ) u_lut (
        .clk_in (clk_in),
        .addr_a (addr_i_s2),
        .addr_b (addr_q_s2),
        .data_a (mag_i_s3),
        .data_b (mag_q_s3)
    );

    // S3: carry sign flags and wrap alongside the table read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v_s3     <= 1'b0;
            wrap_s3  <= 1'b0;
            neg_q_s3 <= 1'b0;
            neg_i_s3 <= 1'b0;
        end else begin
            v_s3     <= v_s2;
            wrap_s3  <= wrap_s2;
            neg_q_s3 <= neg_q_s2;
            neg_i_s3 <= neg_i_s2;
        end
    end

    assign ext_i = {1'b0, mag_i_s3};
    assign ext_q = {1'b0, mag_q_s3};

    // S4: conditional negate into the output registers; samples hold between steps.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            i_out     <= '0;
            q_out     <= '0;
            valid_out <= 1'b0;
            wrap_out  <= 1'b0;
        end else begin
            valid_out <= v_s3;
            wrap_out  <= v_s3 && wrap_s3;
            if (v_s3) begin
                i_out <= neg_i_s3 ? -ext_i : ext_i;
                q_out <= neg_q_s3 ? -ext_q : ext_q;
            end
        end
    end

endmodule

// File: tb/tb_nco_iq.sv
// tb_nco_iq: directed table vectors and randomized traffic for nco_iq, checked
// against a sample-level reference model and a free-running output monitor.
`timescale 1ns/1ps
module tb_nco_iq;
    import nco_pkg::*;

    localparam int          PHASE_W = 32;
    localparam int          LUT_AW  = 8;
    localparam int          AMP_W   = 16;
    localparam int          N       = 1 << LUT_AW;
    localparam logic [31:0] QTR     = 32'h4000_0000;
    localparam logic [31:0] HALF    = 32'h8000_0000;
    localparam int          AMP     = 32767;

    logic                    clk_in       = 1'b0;
    logic                    rst_n_in     = 1'b0;
    logic                    step_in      = 1'b0;
    logic                    sync_in      = 1'b0;
    logic                    cfg_valid_in = 1'b0;
    logic [PHASE_W-1:0]      fcw_in       = '0;
    logic [PHASE_W-1:0]      poff_in      = '0;
    logic                    cfg_ready_out;
    logic signed [AMP_W-1:0] i_out, q_out;
    logic                    valid_out, wrap_out;

    nco_iq #(
        .PHASE_W   (PHASE_W),
        .LUT_AW    (LUT_AW),
        .AMP_W     (AMP_W),
        .FCW_RESET ('0)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .step_in       (step_in),
        .sync_in       (sync_in),
        .cfg_valid_in  (cfg_valid_in),
        .cfg_ready_out (cfg_ready_out),
        .fcw_in        (fcw_in),
        .poff_in       (poff_in),
        .i_out         (i_out),
        .q_out         (q_out),
        .valid_out     (valid_out),
        .wrap_out      (wrap_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int tbl [N];

    function automatic int ref_sin(input logic [31:0] th);
        int k;
        int mag;
        k   = int'(th[29:22]);
        mag = th[30] ? tbl[N-1-k] : tbl[k];
        return th[31] ? -mag : mag;
    endfunction

    function automatic int ref_cos(input logic [31:0] th);
        return ref_sin(th + QTR);
    endfunction

    logic [31:0] m_acc, m_fcw, m_poff, m_fcw_sh, m_poff_sh;
    bit          m_pending;

    // Expected samples keyed by the clock-edge count at which they must appear.
    int exp_tag [16];
    int exp_i   [16];
    int exp_q   [16];
    int exp_w   [16];

    int edge_n = 0;
    always @(posedge clk_in) edge_n <= edge_n + 1;

    int last_i = 0;
    int last_q = 0;

    // Every cycle: either the scheduled sample appears, or nothing does and the
    // outputs hold.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            check("rst_valid", valid_out, 0);
            check("rst_i", i_out, 0);
            check("rst_q", q_out, 0);
            last_i <= 0;
            last_q <= 0;
        end else if (exp_tag[edge_n % 16] == edge_n) begin
            check("mon_valid", valid_out, 1);
            check("mon_i", i_out, exp_i[edge_n % 16]);
            check("mon_q", q_out, exp_q[edge_n % 16]);
            check("mon_wrap", wrap_out, exp_w[edge_n % 16]);
            last_i <= exp_i[edge_n % 16];
            last_q <= exp_q[edge_n % 16];
        end else begin
            check("idle_valid", valid_out, 0);
            check("idle_wrap", wrap_out, 0);
            check("hold_i", i_out, last_i);
            check("hold_q", q_out, last_q);
        end
    end

    task automatic model_reset();
        m_acc     = '0;
        m_fcw     = '0;
        m_poff    = '0;
        m_fcw_sh  = '0;
        m_poff_sh = '0;
        m_pending = 1'b0;
        for (int k = 0; k < 16; k++) exp_tag[k] = -1;
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at posedge+1.
    task automatic drive(input logic st, input logic sy, input logic cv,
                         input logic [31:0] f, input logic [31:0] p);
        logic [31:0] fe, pe, base, th;
        logic [32:0] sum;
        bit          pend0;
        int          due;
        step_in      = st;
        sync_in      = sy;
        cfg_valid_in = cv;
        fcw_in       = f;
        poff_in      = p;
        pend0 = m_pending;
        if (st) begin
            fe   = pend0 ? m_fcw_sh  : m_fcw;
            pe   = pend0 ? m_poff_sh : m_poff;
            base = sy ? 32'd0 : m_acc;
            th   = base + pe;
            sum  = {1'b0, base} + {1'b0, fe};
            due  = edge_n + NCO_LATENCY;
            exp_tag[due % 16] = due;
            exp_i[due % 16]   = ref_cos(th);
            exp_q[due % 16]   = ref_sin(th);
            exp_w[due % 16]   = int'(sum[32]);
            m_acc = sum[31:0];
            if (pend0) begin
                m_fcw     = m_fcw_sh;
                m_poff    = m_poff_sh;
                m_pending = 1'b0;
            end
        end else if (sy) begin
            m_acc = '0;
        end
        if (cv && !pend0) begin
            m_fcw_sh  = f;
            m_poff_sh = p;
            m_pending = 1'b1;
        end
        @(posedge clk_in);
        #1;
        check("cfg_ready", cfg_ready_out, m_pending ? 0 : 1);
        step_in      = 1'b0;
        sync_in      = 1'b0;
        cfg_valid_in = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst_n_in = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    // ---------------- sample capture ----------------
    int got_i [1024];
    int got_q [1024];
    int got_w [1024];
    int got_e [1024];
    int got_n;

    task automatic collect(input int n);
        int waited;
        waited = 0;
        got_n  = 0;
        while (got_n < n && waited < n + 20) begin
            @(negedge clk_in);
            waited++;
            if (valid_out === 1'b1) begin
                got_i[got_n] = i_out;
                got_q[got_n] = q_out;
                got_w[got_n] = int'(wrap_out);
                got_e[got_n] = edge_n;
                got_n++;
            end
        end
        check("sample_count", got_n, n);
    endtask

    // n back-to-back steps; sync on step sync_at, config offer on step cfg_at.
    task automatic burst(input int n, input int sync_at, input int cfg_at,
                         input logic [31:0] f, input logic [31:0] p);
        fork
            for (int k = 0; k < n; k++) drive(1'b1, k == sync_at, k == cfg_at, f, p);
            collect(n);
        join
        @(posedge clk_in);
        #1;
    endtask

    typedef struct {
        int i;
        int q;
        int w;
    } vec_t;

    vec_t qv [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e0;
        real  p, a2;
        for (int k = 0; k < N; k++)
            tbl[k] = $rtoi(32767.0 * $sin(3.14159265358979323846 / 2.0 *
                                          (real'(k) + 0.5) / real'(N)) + 0.5);
        qv[0] = '{ 32767,    101, 0};
        qv[1] = '{  -101,  32767, 0};
        qv[2] = '{-32767,   -101, 0};
        qv[3] = '{   101, -32767, 1};

        rst_n_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        apply_reset(3);

        // Reset state.
        check("reset_i", i_out, 0);
        check("reset_q", q_out, 0);
        check("reset_valid", valid_out, 0);
        check("reset_wrap", wrap_out, 0);
        check("reset_ready", cfg_ready_out, 1);

        // Quarter-step sequence, back to back, with latency and throughput.
        drive(1'b0, 1'b0, 1'b1, QTR, 32'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        e0 = edge_n;
        burst(4, -1, -1, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("quarter_i%0d", k), got_i[k], qv[k].i);
            check($sformatf("quarter_q%0d", k), got_q[k], qv[k].q);
            check($sformatf("quarter_wrap%0d", k), got_w[k], qv[k].w);
            check($sformatf("latency%0d", k), got_e[k], e0 + NCO_LATENCY + k);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            check("no_step_no_valid", valid_out, 0);
        end

        // Config offered together with a step applies on the following step.
        burst(1, -1, 0, QTR, HALF);
        check("hs_same_i", got_i[0], 32767);
        check("hs_same_q", got_q[0], 101);
        check("hs_ready_low", cfg_ready_out, 0);
        burst(1, -1, -1, 32'd0, 32'd0);
        check("hs_neg_i", got_i[0], 101);
        check("hs_neg_q", got_q[0], -32767);
        check("hs_ready_high", cfg_ready_out, 1);

        // Sync on the fourth step restarts the phase.
        drive(1'b0, 1'b0, 1'b1, QTR, 32'd0);
        burst(5, 3, -1, 32'd0, 32'd0);
        check("sync_i", got_i[3], 32767);
        check("sync_q", got_q[3], 101);
        check("sync_next_i", got_i[4], -101);
        check("sync_next_q", got_q[4], 32767);

        // Reset with two samples in flight.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_reset(1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            check("midrst_valid", valid_out, 0);
            check("midrst_i", i_out, 0);
            check("midrst_q", q_out, 0);
        end
        @(posedge clk_in);
        #1;
        drive(1'b0, 1'b0, 1'b1, QTR, 32'd0);
        burst(1, -1, -1, 32'd0, 32'd0);
        check("restart_i", got_i[0], 32767);
        check("restart_q", got_q[0], 101);

        // Full-cycle sweep: magnitude and half-cycle antisymmetry.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'd0);
        burst(1024, -1, -1, 32'd0, 32'd0);
        a2 = real'(AMP) * real'(AMP);
        for (int k = 0; k < 1024; k++) begin
            p = real'(got_i[k]) * real'(got_i[k]) + real'(got_q[k]) * real'(got_q[k]);
            check($sformatf("sweep_power%0d", k),
                  ((p - a2) <= 0.01 * a2 && (a2 - p) <= 0.01 * a2) ? 1 : 0, 1);
        end
        for (int k = 0; k < 512; k++)
            check($sformatf("sweep_sym%0d", k), got_q[k + 512], -got_q[k]);

        // Randomized traffic checked by the monitor.
        for (int k = 0; k < 400; k++)
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0, $urandom, $urandom);
        repeat (8) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nco_iq.md
# nco_iq

Parametrised, runtime-tunable quadrature numerically controlled oscillator (NCO). It produces phase-locked cosine (I) and sine (Q) samples from a shared phase accumulator. A single quarter-wave lookup table (LUT) serves both outputs. The block supersedes the fixed-frequency single-output sine generator: frequency and phase offset are loaded through a valid/ready config port, and phase can be resynchronised on command. It sits between the sample-rate strobe generator and the mixer/DAC paths of the RFID front end.

## Interface
- PHASE_W, 32, accumulator and tuning-word width (≥ LUT_AW+2)
- LUT_AW, 8, quarter-wave table address bits; full-cycle resolution is LUT_AW+2 bits
- AMP_W, 16, signed output width
- FCW_RESET, 0, frequency control word after reset
- clk_in  in  1  sole clock
- rst_n_in  in  1  asynchronous, active-low reset
- step_in  in  1  sample strobe; one output sample per high cycle
- sync_in  in  1  zero the accumulator; the next sample has phase 0
- cfg_valid_in  in  1  config offer
- cfg_ready_out  out  1  config acceptance
- fcw_in  in  PHASE_W  new frequency control word (unsigned)
- poff_in  in  PHASE_W  new phase offset (unsigned, full cycle = 2^PHASE_W)
- i_out  out  AMP_W  signed cos(θ)
- q_out  out  AMP_W  signed sin(θ)
- valid_out  out  1  i_out/q_out carry a new sample
- wrap_out  out  1  this sample's step caused the accumulator to carry out

## Operation
- Reset state: acc=0, fcw=FCW_RESET, poff=0, pending=0. Outputs: i_out=0, q_out=0, valid_out=0, wrap_out=0, cfg_ready_out=1.
- Config is accepted when cfg_valid_in && cfg_ready_out. The accepted values are held in a shadow register and pending=1; cfg_ready_out=!pending.
- Pending config is applied on the next step_in. The new poff applies to that step's sample, and the new fcw is the increment added on that step. pending then clears.
- Acceptance and step_in in the same cycle: the config applies on the following step, not the current one.
- On each step_in:
  - The sample phase is θ = acc + poff (mod 2^PHASE_W), using acc before the update.
  - Then acc ← acc + fcw, with the carry-out recorded as wrap.
- sync_in behaviour:
  - sync_in without step_in: acc ← 0.
  - sync_in with step_in: the sample uses acc=0 and acc ← fcw; sync wins over the stored acc value.
- Table contents: Tbl[k] = round((2^(AMP_W-1)−1)·sin(π/2·(k+0.5)/2^LUT_AW)), for k = 0..2^LUT_AW−1. The half-LSB offset makes the table mirror-symmetric, so negation never overflows.
- Sine from θ: quadrant = θ[PHASE_W-1 -: 2], idx = next LUT_AW bits; lower bits are truncated, with no dithering.
  - quadrant 0 → +Tbl[idx]
  - quadrant 1 → +Tbl[N−1−idx]
  - quadrant 2 → −Tbl[idx]
  - quadrant 3 → −Tbl[N−1−idx]
- Cosine is sine evaluated at θ + 2^(PHASE_W−2).
- Output range: |i_out|, |q_out| ≤ 2^(AMP_W−1)−1, and 0 is never output after the first valid sample.

## Timing
- Pipeline is fixed at 4 stages:
  - S1: accumulate, latch θ
  - S2: quadrant split and index mirror (for I and Q)
  - S3: registered LUT read (two read ports)
  - S4: conditional negate into the output regs
- step_in high in cycle t → valid_out high in cycle t+4 for exactly one cycle, with matching i_out/q_out/wrap_out.
- Back-to-back steps yield back-to-back valid samples; throughput is 1 sample/cycle.
- i_out/q_out hold their last value while valid_out=0; wrap_out is 0 whenever valid_out=0.
- Asserting rst_n_in mid-operation clears all stage-valid bits immediately. In-flight samples are discarded and no valid_out appears after reset release until a new step_in.

## Structure
- Package nco_pkg holds:
  - the quadrant typedef (2-bit enum)
  - the constant NCO_LATENCY=4
  - the table-value function used to initialise the ROM
- Sub-module nco_quarter_lut: dual-read-port registered ROM of 2^LUT_AW × (AMP_W−1) unsigned entries, initialised from the package function.

## Test plan
- Quarter-step sequence: reset; fcw=2^30, poff=0 (PHASE_W=32, LUT_AW=8, AMP_W=16); 4 steps → (I,Q) = (32767,101), (−101,32767), (−32767,−101), (101,−32767); wrap_out=1 only on the 4th sample.
- Latency and throughput: 4 steps on consecutive cycles from cycle 10 → valid_out high in cycles 14–17; no step → no valid.
- Config handshake: offer poff=2^31 in the same cycle as a step → that sample is unchanged, cfg_ready_out=0; the next step's sample is negated relative to the un-offset phase, then cfg_ready_out=1.
- Sync: after 3 steps at fcw=2^30, step with sync_in → sample (32767,101), and the following sample is (−101,32767).
- Reset mid-flight: rst_n_in low one cycle after 2 steps → no valid_out afterwards; outputs 0, acc restarts at 0.
- Symmetry sweep: fcw=2^22 over a full cycle (1024 samples) → I²+Q² within 1% of 32767²; every sample satisfies Q(θ+180°) = −Q(θ) exactly.
